// File: rtl/int_request_ctrl.sv
// Three-level interrupt request controller: edge capture, per-level IDLE/REQ/SERV FSM, one-hot arbitration.
// Ports: clk, clr (sync high) | irq_src/irq_mask/interrupt_running/interrupt_done [2:0] in | interrupt1..3, in_service, pending, lost_count out. Option: IRQ_SYNC_EN adds 2-flop input sync.
module int_request_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic [2:0] irq_src,
  input  logic [2:0] irq_mask,
  input  logic [2:0] interrupt_running,
  input  logic [2:0] interrupt_done,
  output logic       interrupt1,
  output logic       interrupt2,
  output logic       interrupt3,
  output logic [2:0] in_service,
  output logic [2:0] pending,
  output logic [7:0] lost_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } lvl_state_t;

  lvl_state_t state [3];
  logic [2:0] repend;
  logic [2:0] src;
  logic [2:0] prev_src;
  logic [2:0] edges;
  logic [2:0] lost_ev;
  logic [2:0] serv_ge;
  logic [2:0] elig;
  logic [2:0] grant;
  logic [8:0] lost_sum;
  logic [7:0] lost_next;

`ifdef IRQ_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end

  assign src = sync2;
`else
  assign src = irq_src;
`endif

  // Loaded on clr too, so a source already high at release is not an edge.
  always_ff @(posedge clk) begin
    prev_src <= src;
  end

  assign edges = src & ~prev_src & ~irq_mask;

  always_comb begin
    pending    = '0;
    in_service = '0;
    for (int i = 0; i < 3; i++) begin
      pending[i]    = (state[i] == REQ);
      in_service[i] = (state[i] == SERV);
    end
  end

  // Edge dropped: level already requesting, or a repeat is already queued.
  always_comb begin
    lost_ev = '0;
    for (int i = 0; i < 3; i++) begin
      lost_ev[i] = edges[i] &
                   (pending[i] | (in_service[i] & repend[i]));
    end
  end

  always_comb begin
    lost_sum = {1'b0, lost_count}
             + 9'(lost_ev[0])
             + 9'(lost_ev[1])
             + 9'(lost_ev[2]);
    lost_next = (lost_sum > 9'd255) ? 8'd255 : lost_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= IDLE;
      end
      repend <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        unique case (state[i])
          IDLE: begin
            if (edges[i]) state[i] <= REQ;
          end
          REQ: begin
            if (interrupt_running[i]) state[i] <= SERV;
          end
          SERV: begin
            if (interrupt_done[i]) begin
              state[i]  <= (repend[i] | edges[i]) ? REQ : IDLE;
              repend[i] <= 1'b0;
            end else if (edges[i]) begin
              repend[i] <= 1'b1;
            end
          end
          default: begin
            state[i]  <= IDLE;
            repend[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      lost_count <= '0;
    end else begin
      lost_count <= lost_next;
    end
  end

  // A level is blocked by service at its own level or above.
  assign serv_ge[2] = in_service[2];
  assign serv_ge[1] = in_service[2] | in_service[1];
  assign serv_ge[0] = |in_service;

  // A level being accepted this cycle must not re-raise its line.
  assign elig = pending & ~irq_mask & ~serv_ge
              & ~interrupt_running;

  always_comb begin
    grant = '0;
    priority case (1'b1)
      elig[2]: grant = 3'b100;
      elig[1]: grant = 3'b010;
      elig[0]: grant = 3'b001;
      default: grant = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      interrupt1 <= 1'b0;
      interrupt2 <= 1'b0;
      interrupt3 <= 1'b0;
    end else begin
      interrupt1 <= grant[0];
      interrupt2 <= grant[1];
      interrupt3 <= grant[2];
    end
  end

endmodule

// File: tb/tb_int_request_ctrl.sv
// Bench for int_request_ctrl: directed scenarios then random traffic,
// every cycle compared to a behavioural model.
module tb_int_request_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] irq_src;
  logic [2:0] irq_mask;
  logic [2:0] interrupt_running;
  logic [2:0] interrupt_done;
  logic       interrupt1;
  logic       interrupt2;
  logic       interrupt3;
  logic [2:0] in_service;
  logic [2:0] pending;
  logic [7:0] lost_count;

  int checks = 0;
  int errors = 0;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SERV = 2;

  int       m_st [3];
  bit       m_rp [3];
  bit [2:0] m_prev;
  int       m_lost;
  bit [2:0] m_line;

  int_request_ctrl dut (
    .clk               (clk),
    .clr               (clr),
    .irq_src           (irq_src),
    .irq_mask          (irq_mask),
    .interrupt_running (interrupt_running),
    .interrupt_done    (interrupt_done),
    .interrupt1        (interrupt1),
    .interrupt2        (interrupt2),
    .interrupt3        (interrupt3),
    .in_service        (in_service),
    .pending           (pending),
    .lost_count        (lost_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit [2:0] e;
    if (clr) begin
      for (int l = 0; l < 3; l++) begin
        m_st[l] = M_IDLE;
        m_rp[l] = 1'b0;
      end
      m_lost = 0;
      m_line = 3'b000;
      m_prev = irq_src;
      return;
    end
    e = irq_src & ~m_prev & ~irq_mask;
    // Scan from the top: a serving level stops the scan,
    // the first ready requester wins.
    m_line = 3'b000;
    for (int l = 2; l >= 0; l--) begin
      if (m_st[l] == M_SERV) break;
      if (m_st[l] == M_REQ && !irq_mask[l] &&
          !interrupt_running[l]) begin
        m_line[l] = 1'b1;
        break;
      end
    end
    for (int l = 0; l < 3; l++) begin
      if (m_st[l] == M_IDLE) begin
        if (e[l]) m_st[l] = M_REQ;
      end else if (m_st[l] == M_REQ) begin
        if (e[l]) m_lost++;
        if (interrupt_running[l]) m_st[l] = M_SERV;
      end else begin
        if (e[l] && m_rp[l]) m_lost++;
        if (interrupt_done[l]) begin
          m_st[l] = (m_rp[l] || e[l]) ? M_REQ : M_IDLE;
          m_rp[l] = 1'b0;
        end else if (e[l]) begin
          m_rp[l] = 1'b1;
        end
      end
    end
    if (m_lost > 255) m_lost = 255;
    m_prev = irq_src;
  endtask

  task automatic tick();
    bit [2:0] ep;
    bit [2:0] es;
    @(posedge clk);
    model_step();
    #1;
    for (int l = 0; l < 3; l++) begin
      ep[l] = (m_st[l] == M_REQ);
      es[l] = (m_st[l] == M_SERV);
    end
    chk("pending", int'(pending), int'(ep));
    chk("in_service", int'(in_service), int'(es));
    chk("lines", int'({interrupt3, interrupt2, interrupt1}),
        int'(m_line));
    chk("lost_count", int'(lost_count), m_lost);
  endtask

  task automatic idle_in();
    interrupt_running = 3'b000;
    interrupt_done    = 3'b000;
  endtask

  initial begin
    clr = 1'b1;
    irq_src = 3'b000;
    irq_mask = 3'b000;
    idle_in();
    m_prev = 3'b000;
    m_lost = 0;
    m_line = 3'b000;
    for (int l = 0; l < 3; l++) begin
      m_st[l] = M_IDLE;
      m_rp[l] = 1'b0;
    end

    // reset state
    tick();
    chk("rst_out", int'({interrupt3, interrupt2, interrupt1,
        in_service, pending}), 0);
    chk("rst_lost", int'(lost_count), 0);
    clr = 1'b0;
    tick();

    // single edge on level 1, full service cycle
    irq_src = 3'b001;
    tick();
    chk("s1_pend", int'(pending), 1);
    chk("s1_line_early", int'(interrupt1), 0);
    tick();
    chk("s1_line", int'(interrupt1), 1);
    tick();
    tick();
    interrupt_running = 3'b001;
    tick();
    chk("s1_line_off", int'(interrupt1), 0);
    chk("s1_serv", int'(in_service), 1);
    interrupt_running = 3'b000;
    tick();
    chk("s1_hold", int'(interrupt1), 0);
    interrupt_done = 3'b001;
    tick();
    chk("s1_done", int'(in_service), 0);
    interrupt_done = 3'b000;
    irq_src = 3'b000;
    tick();

    // simultaneous edges: level 3 first, then level 1
    irq_src = 3'b101;
    tick();
    chk("s2_pend", int'(pending), 5);
    tick();
    chk("s2_lines", int'({interrupt3, interrupt2, interrupt1}), 4);
    interrupt_running = 3'b100;
    tick();
    interrupt_running = 3'b000;
    tick();
    chk("s2_block", int'({interrupt3, interrupt2, interrupt1}), 0);
    interrupt_done = 3'b100;
    tick();
    interrupt_done = 3'b000;
    tick();
    chk("s2_l1", int'({interrupt3, interrupt2, interrupt1}), 1);
    interrupt_running = 3'b001;
    tick();
    interrupt_running = 3'b000;
    irq_src = 3'b000;
    tick();

    // nested: level 2 preempts service of level 1
    irq_src = 3'b010;
    tick();
    tick();
    chk("s3_l2", int'(interrupt2), 1);
    interrupt_running = 3'b010;
    tick();
    interrupt_running = 3'b000;
    // repeated edges on level 2 while serving
    irq_src = 3'b000;
    tick();
    irq_src = 3'b010;
    tick();
    irq_src = 3'b000;
    tick();
    irq_src = 3'b010;
    tick();
    chk("s4_lost", int'(lost_count), 1);
    interrupt_done = 3'b010;
    tick();
    interrupt_done = 3'b000;
    chk("s4_repend", int'(pending), 2);
    tick();
    chk("s4_l2_again", int'(interrupt2), 1);
    interrupt_running = 3'b010;
    tick();
    interrupt_running = 3'b000;
    interrupt_done = 3'b111;
    tick();
    idle_in();
    irq_src = 3'b000;
    tick();

    // saturation: 300 edges on level 1 with running low
    for (int k = 0; k < 300; k++) begin
      irq_src = 3'b001;
      tick();
      irq_src = 3'b000;
      tick();
    end
    chk("sat_lost", int'(lost_count), 255);

    // reset mid-activity with all sources held high
    irq_src = 3'b101;
    tick();
    interrupt_running = 3'b100;
    tick();
    irq_src = 3'b111;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    interrupt_running = 3'b111;
    interrupt_done = 3'b111;
    tick();
    tick();
    chk("clr_out", int'({interrupt3, interrupt2, interrupt1,
        in_service, pending}), 0);
    chk("clr_lost", int'(lost_count), 0);
    idle_in();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 3) == 0) irq_src[b] = ~irq_src[b];
        irq_mask[b] = ($urandom_range(0, 9) == 0);
        interrupt_running[b] = ($urandom_range(0, 3) == 0);
        interrupt_done[b] = ($urandom_range(0, 4) == 0);
      end
      clr = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
